// File: rtl/axi_write_arbiter_pkg.sv
// Shared AXI master-boundary definitions used by the read and write arbiters.
package axi_write_arbiter_pkg;

  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned DATA_W  = 64;
  localparam int unsigned STRB_W  = 8;
  localparam int unsigned LINE_W  = 128;
  localparam int unsigned ID_W    = 4;
  localparam int unsigned LEN_W   = 8;
  localparam int unsigned SIZE_W  = 3;
  localparam int unsigned BURST_W = 2;
  localparam int unsigned RESP_W  = 2;

  // Per-requester AXI IDs, shared with the read-address arbiter
  localparam logic [ID_W-1:0] AXI_ID_FLASH  = 4'd0;
  localparam logic [ID_W-1:0] AXI_ID_DCACHE = 4'd1;
  localparam logic [ID_W-1:0] AXI_ID_DEVICE = 4'd2;
  localparam logic [ID_W-1:0] AXI_ID_ICACHE = 4'd3;

  localparam logic [BURST_W-1:0] BURST_FIXED = 2'b00;
  localparam logic [BURST_W-1:0] BURST_INCR  = 2'b01;

  localparam logic [SIZE_W-1:0] SIZE_8B = 3'b011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_AW   = 2'd1,
    ST_W    = 2'd2,
    ST_B    = 2'd3
  } wr_state_e;

  typedef enum logic {
    OWN_DC  = 1'b0,
    OWN_DEV = 1'b1
  } owner_e;

  // Fully latched write transaction; Device data lives in data[63:0]
  typedef struct packed {
    owner_e              owner;
    logic [ADDR_W-1:0]   addr;
    logic [LINE_W-1:0]   data;
    logic [STRB_W-1:0]   strb;
    logic [SIZE_W-1:0]   size;
  } wr_txn_t;

endpackage

// File: rtl/axi_write_arbiter_rr_arb2.sv
// Two-way round-robin picker between D-cache and Device with a last-grant register.
module rr_arb2
  import axi_write_arbiter_pkg::*;
(
  input  logic   clock,
  input  logic   reset,
  input  logic   req_dc,
  input  logic   req_dev,
  input  logic   update,
  input  owner_e owner,
  output logic   grant_valid_c,
  output owner_e grant_c
);

  owner_e last_grant_q;

  // Remember who completed last; Device after reset so the D-cache wins the first tie
  always_ff @(posedge clock) begin
    if (reset) begin
      last_grant_q <= OWN_DEV;
    end else if (update) begin
      last_grant_q <= owner;
    end
  end

  // Single requester wins outright; a tie goes to the one not served last
  always_comb begin
    grant_valid_c = req_dc | req_dev;
    grant_c       = OWN_DC;
    if (req_dc && req_dev) begin
      grant_c = (last_grant_q == OWN_DEV) ? OWN_DC : OWN_DEV;
    end else if (req_dev) begin
      grant_c = OWN_DEV;
    end
  end

endmodule

// File: rtl/axi_write_arbiter.sv
// Shares the AXI4 AW/W/B write path between D-cache writebacks and Device stores.
module axi_write_arbiter
  import axi_write_arbiter_pkg::*;
#(
  parameter logic [ID_W-1:0] DC_ID  = AXI_ID_DCACHE,
  parameter logic [ID_W-1:0] DEV_ID = AXI_ID_DEVICE
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                dc_req,
  input  logic [ADDR_W-1:0]   dc_addr,
  input  logic [LINE_W-1:0]   dc_line,
  output logic                dc_done,
  output logic [RESP_W-1:0]   dc_bresp,
  input  logic                dev_req,
  input  logic [ADDR_W-1:0]   dev_addr,
  input  logic [SIZE_W-1:0]   dev_size,
  input  logic [DATA_W-1:0]   dev_wdata,
  input  logic [STRB_W-1:0]   dev_wstrb,
  output logic                dev_done,
  output logic [RESP_W-1:0]   dev_bresp,
  output logic                awvalid,
  input  logic                awready,
  output logic [ID_W-1:0]     awid,
  output logic [ADDR_W-1:0]   awaddr,
  output logic [LEN_W-1:0]    awlen,
  output logic [SIZE_W-1:0]   awsize,
  output logic [BURST_W-1:0]  awburst,
  output logic                wvalid,
  input  logic                wready,
  output logic [DATA_W-1:0]   wdata,
  output logic [STRB_W-1:0]   wstrb,
  output logic                wlast,
  input  logic                bvalid,
  output logic                bready,
  input  logic [ID_W-1:0]     bid,
  input  logic [RESP_W-1:0]   bresp,
  output logic                id_err
);

  wr_state_e state_q, state_d;
  wr_txn_t   txn_q, txn_d;
  logic      beat_q, beat_d;

  logic                awvalid_d, wvalid_d, wlast_d, bready_d;
  logic [ID_W-1:0]     awid_d;
  logic [ADDR_W-1:0]   awaddr_d;
  logic [LEN_W-1:0]    awlen_d;
  logic [SIZE_W-1:0]   awsize_d;
  logic [BURST_W-1:0]  awburst_d;
  logic [DATA_W-1:0]   wdata_d;
  logic [STRB_W-1:0]   wstrb_d;
  logic                dc_done_d, dev_done_d, id_err_d;
  logic [RESP_W-1:0]   dc_bresp_d, dev_bresp_d;

  logic   grant_valid_c;
  owner_e grant_c;
  logic   arb_update_c;
  logic   owner_is_dc_c;
  logic [ID_W-1:0] owner_id_c;

  rr_arb2 u_rr_arb2 (
    .clock         (clock),
    .reset         (reset),
    .req_dc        (dc_req),
    .req_dev       (dev_req),
    .update        (arb_update_c),
    .owner         (txn_q.owner),
    .grant_valid_c (grant_valid_c),
    .grant_c       (grant_c)
  );

  assign owner_is_dc_c = (txn_q.owner == OWN_DC);
  assign owner_id_c    = owner_is_dc_c ? DC_ID : DEV_ID;

  // State, latched transaction and every output register
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      txn_q     <= '0;
      beat_q    <= 1'b0;
      awvalid   <= 1'b0;
      awid      <= '0;
      awaddr    <= '0;
      awlen     <= '0;
      awsize    <= '0;
      awburst   <= '0;
      wvalid    <= 1'b0;
      wdata     <= '0;
      wstrb     <= '0;
      wlast     <= 1'b0;
      bready    <= 1'b0;
      dc_done   <= 1'b0;
      dc_bresp  <= '0;
      dev_done  <= 1'b0;
      dev_bresp <= '0;
      id_err    <= 1'b0;
    end else begin
      state_q   <= state_d;
      txn_q     <= txn_d;
      beat_q    <= beat_d;
      awvalid   <= awvalid_d;
      awid      <= awid_d;
      awaddr    <= awaddr_d;
      awlen     <= awlen_d;
      awsize    <= awsize_d;
      awburst   <= awburst_d;
      wvalid    <= wvalid_d;
      wdata     <= wdata_d;
      wstrb     <= wstrb_d;
      wlast     <= wlast_d;
      bready    <= bready_d;
      dc_done   <= dc_done_d;
      dc_bresp  <= dc_bresp_d;
      dev_done  <= dev_done_d;
      dev_bresp <= dev_bresp_d;
      id_err    <= id_err_d;
    end
  end

  // Grant, then sequence AW -> W beats -> B; payload fields hold until their handshake
  always_comb begin
    state_d      = state_q;
    txn_d        = txn_q;
    beat_d       = beat_q;
    awvalid_d    = awvalid;
    awid_d       = awid;
    awaddr_d     = awaddr;
    awlen_d      = awlen;
    awsize_d     = awsize;
    awburst_d    = awburst;
    wvalid_d     = wvalid;
    wdata_d      = wdata;
    wstrb_d      = wstrb;
    wlast_d      = wlast;
    bready_d     = bready;
    dc_done_d    = 1'b0;
    dc_bresp_d   = '0;
    dev_done_d   = 1'b0;
    dev_bresp_d  = '0;
    id_err_d     = id_err;
    arb_update_c = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Skip the done cycle so a requester dropping req on done is not re-granted
        if (grant_valid_c && !dc_done && !dev_done) begin
          txn_d.owner = grant_c;
          if (grant_c == OWN_DC) begin
            txn_d.addr = dc_addr;
            txn_d.data = dc_line;
            txn_d.strb = '1;
            txn_d.size = SIZE_8B;
          end else begin
            txn_d.addr = dev_addr;
            txn_d.data = {DATA_W'(0), dev_wdata};
            txn_d.strb = dev_wstrb;
            txn_d.size = dev_size;
          end
          state_d = ST_AW;
        end
      end

      ST_AW: begin
        if (!awvalid) begin
          awvalid_d = 1'b1;
          awid_d    = owner_id_c;
          awaddr_d  = txn_q.addr;
          awlen_d   = owner_is_dc_c ? LEN_W'(1) : LEN_W'(0);
          awsize_d  = txn_q.size;
          awburst_d = owner_is_dc_c ? BURST_INCR : BURST_FIXED;
        end else if (awready) begin
          awvalid_d = 1'b0;
          wvalid_d  = 1'b1;
          beat_d    = 1'b0;
          wdata_d   = txn_q.data[DATA_W-1:0];
          wstrb_d   = txn_q.strb;
          wlast_d   = !owner_is_dc_c;
          state_d   = ST_W;
        end
      end

      ST_W: begin
        if (wvalid && wready) begin
          if (wlast) begin
            wvalid_d = 1'b0;
            bready_d = 1'b1;
            state_d  = ST_B;
          end else if (!beat_q) begin
            beat_d  = 1'b1;
            wdata_d = txn_q.data[LINE_W-1:DATA_W];
            wlast_d = 1'b1;
          end
        end
      end

      ST_B: begin
        if (bvalid && bready) begin
          bready_d     = 1'b0;
          state_d      = ST_IDLE;
          arb_update_c = 1'b1;
          if (owner_is_dc_c) begin
            dc_done_d  = 1'b1;
            dc_bresp_d = bresp;
          end else begin
            dev_done_d  = 1'b1;
            dev_bresp_d = bresp;
          end
          if (bid != owner_id_c) begin
            id_err_d = 1'b1;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: doc/axi_write_arbiter.md
Name: axi_write_arbiter

Overview:
- Shares the single AXI4 write path (AW/W/B) between two requesters: the D-cache writeback (2-beat line burst) and the uncached Device store path (single beat).
- Latches the winning request in full, sequences AW, then W beats, then B, and returns a one-cycle done pulse with BRESP to the owner.
- Sits beside the read-address arbiter at the core's AXI4 master boundary and uses the same per-requester AXI IDs.

Parameters:
- DC_ID, 4'b0001, AWID used for D-cache writebacks
- DEV_ID, 4'b0010, AWID used for Device stores

Ports:
- clock  in  1  clock
- reset  in  1  reset, synchronous, active-high
- dc_req  in  1  D-cache writeback request; held until dc_done
- dc_addr  in  32  line address, 16-byte aligned
- dc_line  in  128  line data; beat0 = [63:0], beat1 = [127:64]
- dc_done  out  1  one-cycle pulse on writeback completion
- dc_bresp  out  2  BRESP, valid with dc_done
- dev_req  in  1  Device store request; held until dev_done
- dev_addr  in  32  store address
- dev_size  in  3  AWSIZE for the store
- dev_wdata  in  64  store data, lane-aligned
- dev_wstrb  in  8  byte strobes
- dev_done  out  1  one-cycle completion pulse
- dev_bresp  out  2  BRESP, valid with dev_done
- awvalid  out  1  AXI AW valid
- awready  in  1  AXI AW ready
- awid  out  4  AXI AW ID
- awaddr  out  32  AXI AW address
- awlen  out  8  AXI AW burst length
- awsize  out  3  AXI AW size
- awburst  out  2  AXI AW burst type
- wvalid  out  1  AXI W valid
- wready  in  1  AXI W ready
- wdata  out  64  AXI W data
- wstrb  out  8  AXI W strobes
- wlast  out  1  AXI W last
- bvalid  in  1  AXI B valid
- bready  out  1  AXI B ready
- bid  in  4  AXI B ID
- bresp  in  2  AXI B response
- id_err  out  1  sticky flag: BID did not match the granted ID

Behaviour:
- Reset: FSM goes to IDLE. All outputs are 0, including id_err. last_grant = DEV, so D-cache wins the first tie.
- FSM states: IDLE, AW, W, B. All AXI outputs are registered.
- IDLE, requests present:
  - Only one request: grant it.
  - Both requests: grant the requester not equal to last_grant.
  - On grant, latch owner, address, data, strobes and size. Next cycle: state = AW, awvalid = 1.
- IDLE, done holdoff: requests are ignored in any cycle where dc_done or dev_done is high, so a requester that drops req on done is never re-granted.
- Latency: req sampled high in IDLE at edge N → awvalid high after edge N+1.
- AW fields:
  - D-cache: awid = DC_ID, awlen = 1, awsize = 3'b011, awburst = INCR (2'b01).
  - Device: awid = DEV_ID, awlen = 0, awsize = dev_size, awburst = FIXED (2'b00).
- AW: awvalid and all AW fields stay stable until awvalid & awready. Then awvalid = 0, wvalid = 1, beat = 0, state = W.
- W beats:
  - D-cache: beat 0 = dc_line[63:0], wstrb = 8'hFF, wlast = 0. Beat 1 = dc_line[127:64], wlast = 1.
  - Device: one beat of dev_wdata / dev_wstrb with wlast = 1.
  - wdata, wstrb and wlast stay stable until wvalid & wready.
- W handshake:
  - With wlast = 0: beat increments; wvalid stays high with beat-1 data on the next cycle.
  - With wlast = 1: wvalid = 0, bready = 1, state = B.
  - Beat counter is 1 bit; it never wraps past 1.
- B: bready stays high until bvalid & bready. On that handshake:
  - bready = 0 and state = IDLE.
  - The owner's done pulses on the next cycle with the latched BRESP.
  - last_grant = owner.
  - If bid ≠ the granted ID, id_err is set (sticky until reset); the response is still delivered to the owner.
- Simultaneous AW and B: no overlap. AW and W are never valid together, and only one transaction is outstanding.
- A requester dropping req mid-transaction has no effect; the latched transaction completes and done still pulses.
- Reset mid-transaction: the transaction is abandoned; no done pulse. Requesters re-issue after reset.
- A non-OKAY BRESP is passed through unchanged; no retry.

Decomposition:
- Shared package (also used by the read arbiter):
  - AXI ID constants: FLASH 0, DCACHE 1, DEVICE 2, ICACHE 3.
  - BURST_FIXED / BURST_INCR encodings.
  - FSM state enum.
  - SIZE_8B = 3'b011.
- Optional sub-module: rr_arb2, a two-way round-robin picker with a last_grant register.
- Everything else stays flat.

Test Plan:
- D-cache only, dc_addr = 0x8000_0010, line = {B, A}, awready/wready/bvalid = 1:
  - AW: awid = 1, awlen = 1, awsize = 3, awburst = 1.
  - W: beats A then B, wlast on the second beat only.
  - dc_done one cycle with bresp = 0.
- Device only, addr = 0xA000_03F8, size = 0, wstrb = 8'h01:
  - awlen = 0, awburst = 0, awsize = 0, awid = 2.
  - Single beat with wlast = 1; dev_done pulses.
- Both requesters high from reset:
  - D-cache is granted first.
  - With both held high, grants alternate DC, DEV, DC; each done precedes the next awvalid.
- Back-pressure: awready low 3 cycles, wready low 2 cycles on beat 0, bvalid delayed 4 cycles:
  - AW and W fields stay stable throughout; exactly 2 W handshakes; one done pulse.
- bid = 3 returned for a D-cache write: id_err = 1 and stays set; dc_done still pulses with that bresp.
- Reset asserted while in state W (after beat 0):
  - All outputs go to 0; no done pulse.
  - The next dc_req restarts at AW with beat 0.
